// File: rtl/trigger_level_ctrl.sv
// trigger_level_ctrl
// Holds the two 8-bit DAC reference levels (channel 1 = trigger, channel 2 = auxiliary).
// Two raw front-panel buttons are synchronized, debounced and auto-repeated to step the
// level selected by ch_target, saturating at 0 and 255. Shadow copies of both levels only
// follow the live levels while cs_n is high, so ref_level is frozen during a DAC transfer.
//
// Ports:
//   clk            system clock (shared with the SPI MOSI stage)
//   reset_n        synchronous active-low reset
//   level_up_n     raw up button, active-low, asynchronous, bouncy
//   level_down_n   raw down button, active-low, asynchronous, bouncy
//   ch_target      level adjusted by the buttons (0 = ch1, 1 = ch2)
//   channel_sel    channel the MOSI stage is writing (0 = ch1, 1 = ch2)
//   cs_n           DAC chip select from the MOSI stage, 1 = idle
//   ref_level      shadow level of the channel picked by channel_sel
//   level_ch1      live channel 1 level
//   level_ch2      live channel 2 level
//   update_pending a live level differs from its shadow
module trigger_level_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 4096,
  parameter int unsigned REPEAT_RATE     = 512,
  parameter logic [7:0]  INIT_LEVEL      = 8'd128,
  parameter logic [7:0]  STEP            = 8'd1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       level_up_n,
  input  logic       level_down_n,
  input  logic       ch_target,
  input  logic       channel_sel,
  input  logic       cs_n,
  output logic [7:0] ref_level,
  output logic [7:0] level_ch1,
  output logic [7:0] level_ch2,
  output logic       update_pending
);

  localparam int unsigned DbW     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HoldW   = (HoldMax > 2) ? $clog2(HoldMax) : 1;

  localparam logic [DbW-1:0]   DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] DelayLast = HoldW'(REPEAT_DELAY - 1);
  localparam logic [HoldW-1:0] RateLast  = HoldW'(REPEAT_RATE - 1);

  // Button index 0 = up, 1 = down. Sync/debounce registers keep the active-low polarity.
  logic [1:0]       w_raw_n;
  logic [1:0]       r_sync1_n;
  logic [1:0]       r_sync2_n;
  logic [1:0]       r_deb_n;
  logic [DbW-1:0]   r_db_cnt [2];
  logic [1:0]       r_prs_prev;
  logic [HoldW-1:0] r_hold   [2];
  logic [1:0]       r_rep;

  logic [7:0] r_level_ch1;
  logic [7:0] r_level_ch2;
  logic [7:0] r_shadow_ch1;
  logic [7:0] r_shadow_ch2;

  logic [1:0]       w_pressed;
  logic [1:0]       w_active;
  logic [1:0]       w_step;
  logic [HoldW-1:0] w_hold_d [2];
  logic [1:0]       w_rep_d;
  logic [7:0]       w_sel_level;
  logic [8:0]       w_sum;
  logic [7:0]       w_new_level;

  assign w_raw_n   = {level_down_n, level_up_n};
  assign w_pressed = ~r_deb_n;

  // Step and hold-counter next state. A button is only active while the other one is
  // released, so up and down steps can never coincide.
  always_comb begin
    w_active = 2'b00;
    w_step   = 2'b00;
    w_rep_d  = 2'b00;
    for (int b = 0; b < 2; b++) begin
      w_hold_d[b] = '0;
      w_active[b] = w_pressed[b] & ~w_pressed[1-b];
      if (w_active[b]) begin
        if (!r_prs_prev[b]) begin
          // Fresh press: step now, restart the delay phase.
          w_step[b] = 1'b1;
        end else if ((!r_rep[b] && r_hold[b] == DelayLast) ||
                     (r_rep[b] && r_hold[b] == RateLast)) begin
          w_step[b]  = 1'b1;
          w_rep_d[b] = 1'b1;
        end else begin
          w_hold_d[b] = r_hold[b] + 1'b1;
          w_rep_d[b]  = r_rep[b];
        end
      end
    end
  end

  // Saturating add/subtract on the targeted level.
  always_comb begin
    w_sel_level = ch_target ? r_level_ch2 : r_level_ch1;
    w_sum       = {1'b0, w_sel_level} + {1'b0, STEP};
    w_new_level = w_sel_level;
    if (w_step[0]) begin
      w_new_level = w_sum[8] ? 8'hFF : w_sum[7:0];
    end else if (w_step[1]) begin
      w_new_level = (w_sel_level < STEP) ? 8'h00 : (w_sel_level - STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1_n    <= 2'b11;
      r_sync2_n    <= 2'b11;
      r_deb_n      <= 2'b11;
      r_prs_prev   <= 2'b00;
      r_rep        <= 2'b00;
      r_level_ch1  <= INIT_LEVEL;
      r_level_ch2  <= INIT_LEVEL;
      r_shadow_ch1 <= INIT_LEVEL;
      r_shadow_ch2 <= INIT_LEVEL;
      for (int b = 0; b < 2; b++) begin
        r_db_cnt[b] <= '0;
        r_hold[b]   <= '0;
      end
    end else begin
      r_sync1_n  <= w_raw_n;
      r_sync2_n  <= r_sync1_n;
      r_prs_prev <= w_pressed;
      r_rep      <= w_rep_d;
      for (int b = 0; b < 2; b++) begin
        r_hold[b] <= w_hold_d[b];
        if (r_sync2_n[b] == r_deb_n[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DbLast) begin
          r_deb_n[b]  <= r_sync2_n[b];
          r_db_cnt[b] <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
        end
      end
      if (ch_target) begin
        r_level_ch2 <= w_new_level;
      end else begin
        r_level_ch1 <= w_new_level;
      end
      // Shadows sample the pre-step levels; a same-edge step lands on the next idle edge.
      if (cs_n) begin
        r_shadow_ch1 <= r_level_ch1;
        r_shadow_ch2 <= r_level_ch2;
      end
    end
  end

  assign ref_level      = channel_sel ? r_shadow_ch2 : r_shadow_ch1;
  assign level_ch1      = r_level_ch1;
  assign level_ch2      = r_level_ch2;
  assign update_pending = (r_level_ch1 != r_shadow_ch1) | (r_level_ch2 != r_shadow_ch2);

endmodule
